// File: rtl/issue_queue_if.sv
// Handshake bundle between rename, writeback, the issue queue and execute.
// The queue attaches through the slave modport; the producer/consumer side uses master.
interface issue_queue_if #(
  parameter int DEPTH         = 16,
  parameter int PHYS_BITS     = 6,
  parameter int NUM_PHYS_REGS = 64,
  parameter int PAYLOAD_W     = 96
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                     flush;
  logic                     enq_valid;
  logic                     enq_ready;
  logic                     enq_uses_rs;
  logic [PHYS_BITS-1:0]     enq_rs_phys;
  logic                     enq_uses_rt;
  logic [PHYS_BITS-1:0]     enq_rt_phys;
  logic [PHYS_BITS-1:0]     enq_rw_phys;
  logic [PAYLOAD_W-1:0]     enq_payload;
  logic [NUM_PHYS_REGS-1:0] busy_bits;
  logic                     wb_valid;
  logic [PHYS_BITS-1:0]     wb_phys;
  logic                     iss_valid;
  logic                     iss_ready;
  logic [PHYS_BITS-1:0]     iss_rs_phys;
  logic [PHYS_BITS-1:0]     iss_rt_phys;
  logic [PHYS_BITS-1:0]     iss_rw_phys;
  logic [PAYLOAD_W-1:0]     iss_payload;
  logic [CNT_W-1:0]         count;

  modport master (
    output flush, enq_valid, enq_uses_rs, enq_rs_phys, enq_uses_rt, enq_rt_phys,
           enq_rw_phys, enq_payload, busy_bits, wb_valid, wb_phys, iss_ready,
    input  enq_ready, iss_valid, iss_rs_phys, iss_rt_phys, iss_rw_phys, iss_payload, count
  );

  modport slave (
    input  flush, enq_valid, enq_uses_rs, enq_rs_phys, enq_uses_rt, enq_rt_phys,
           enq_rw_phys, enq_payload, busy_bits, wb_valid, wb_phys, iss_ready,
    output enq_ready, iss_valid, iss_rs_phys, iss_rt_phys, iss_rw_phys, iss_payload, count
  );
endinterface

// File: rtl/issue_queue.sv
// Collapsing out-of-order issue queue: slot 0 is oldest, oldest ready entry issues,
// younger entries shift down on issue, wakeup from busy bits and writeback broadcasts.
module issue_queue #(
  parameter int DEPTH         = 16,
  parameter int PHYS_BITS     = 6,
  parameter int NUM_PHYS_REGS = 64,
  parameter int PAYLOAD_W     = 96
) (
  input logic          clk,
  input logic          rst,
  issue_queue_if.slave io
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     rs_rdy_q, rs_rdy_d;
  logic [DEPTH-1:0]     rt_rdy_q, rt_rdy_d;
  logic [PHYS_BITS-1:0] rs_q [DEPTH];
  logic [PHYS_BITS-1:0] rs_d [DEPTH];
  logic [PHYS_BITS-1:0] rt_q [DEPTH];
  logic [PHYS_BITS-1:0] rt_d [DEPTH];
  logic [PHYS_BITS-1:0] rw_q [DEPTH];
  logic [PHYS_BITS-1:0] rw_d [DEPTH];
  logic [PAYLOAD_W-1:0] pay_q [DEPTH];
  logic [PAYLOAD_W-1:0] pay_d [DEPTH];
  logic [CNT_W-1:0]     count_q, count_d;

  // Woken view of every slot plus one empty slot past the end, so slot i can
  // always read slot i+1 when collapsing.
  logic [DEPTH:0]       rs_rdy_x, rt_rdy_x;
  logic [PHYS_BITS-1:0] rs_x [DEPTH+1];
  logic [PHYS_BITS-1:0] rt_x [DEPTH+1];
  logic [PHYS_BITS-1:0] rw_x [DEPTH+1];
  logic [PAYLOAD_W-1:0] pay_x [DEPTH+1];

  logic [DEPTH-1:0] ready_vec;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             enq_fire, iss_fire;
  logic             enq_rs_rdy, enq_rt_rdy;
  logic [CNT_W-1:0] enq_slot;

  assign ready_vec = valid_q & rs_rdy_q & rt_rdy_q;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    io.iss_rs_phys = '0;
    io.iss_rt_phys = '0;
    io.iss_rw_phys = '0;
    io.iss_payload = '0;
    if (sel_found) begin
      io.iss_rs_phys = rs_q[sel_idx];
      io.iss_rt_phys = rt_q[sel_idx];
      io.iss_rw_phys = rw_q[sel_idx];
      io.iss_payload = pay_q[sel_idx];
    end
  end

  assign io.iss_valid = sel_found;
  assign io.count     = count_q;
  // No full-queue bypass: a slot freed by this cycle's issue is only usable next cycle.
  assign io.enq_ready = (count_q < CNT_W'(DEPTH)) && !io.flush && !rst;
  assign enq_fire     = io.enq_valid && io.enq_ready;
  assign iss_fire     = sel_found && io.iss_ready;
  assign enq_slot     = count_q - CNT_W'(iss_fire);

  assign enq_rs_rdy = !io.enq_uses_rs || !io.busy_bits[io.enq_rs_phys] ||
                      (io.wb_valid && (io.wb_phys == io.enq_rs_phys));
  assign enq_rt_rdy = !io.enq_uses_rt || !io.busy_bits[io.enq_rt_phys] ||
                      (io.wb_valid && (io.wb_phys == io.enq_rt_phys));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rs_rdy_x[i] = rs_rdy_q[i] | (io.wb_valid && (io.wb_phys == rs_q[i]));
      rt_rdy_x[i] = rt_rdy_q[i] | (io.wb_valid && (io.wb_phys == rt_q[i]));
      rs_x[i]     = rs_q[i];
      rt_x[i]     = rt_q[i];
      rw_x[i]     = rw_q[i];
      pay_x[i]    = pay_q[i];
    end
    rs_rdy_x[DEPTH] = 1'b0;
    rt_rdy_x[DEPTH] = 1'b0;
    rs_x[DEPTH]     = '0;
    rt_x[DEPTH]     = '0;
    rw_x[DEPTH]     = '0;
    pay_x[DEPTH]    = '0;
  end

  always_comb begin
    count_d = io.flush ? '0 : (count_q + CNT_W'(enq_fire) - CNT_W'(iss_fire));
    for (int i = 0; i < DEPTH; i++) begin
      if (iss_fire && (IDX_W'(i) >= sel_idx)) begin
        rs_rdy_d[i] = rs_rdy_x[i+1];
        rt_rdy_d[i] = rt_rdy_x[i+1];
        rs_d[i]     = rs_x[i+1];
        rt_d[i]     = rt_x[i+1];
        rw_d[i]     = rw_x[i+1];
        pay_d[i]    = pay_x[i+1];
      end else begin
        rs_rdy_d[i] = rs_rdy_x[i];
        rt_rdy_d[i] = rt_rdy_x[i];
        rs_d[i]     = rs_x[i];
        rt_d[i]     = rt_x[i];
        rw_d[i]     = rw_x[i];
        pay_d[i]    = pay_x[i];
      end
      if (enq_fire && (enq_slot == CNT_W'(i))) begin
        rs_rdy_d[i] = enq_rs_rdy;
        rt_rdy_d[i] = enq_rt_rdy;
        rs_d[i]     = io.enq_rs_phys;
        rt_d[i]     = io.enq_rt_phys;
        rw_d[i]     = io.enq_rw_phys;
        pay_d[i]    = io.enq_payload;
      end
      valid_d[i] = CNT_W'(i) < count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      valid_q  <= '0;
      rs_rdy_q <= '0;
      rt_rdy_q <= '0;
    end else begin
      count_q  <= count_d;
      valid_q  <= valid_d;
      rs_rdy_q <= rs_rdy_d;
      rt_rdy_q <= rt_rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      rs_q[i]  <= rs_d[i];
      rt_q[i]  <= rt_d[i];
      rw_q[i]  <= rw_d[i];
      pay_q[i] <= pay_d[i];
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: fill/full, oldest-ready select, wakeup timing,
// enqueue bypass, collapse on issue, flush priority and asynchronous reset.
module tb_issue_queue;
  localparam int DEPTH = 16;
  localparam int PB    = 6;
  localparam int NPR   = 64;
  localparam int PW    = 96;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  issue_queue_if #(.DEPTH(DEPTH), .PHYS_BITS(PB), .NUM_PHYS_REGS(NPR), .PAYLOAD_W(PW)) ifc ();

  issue_queue #(.DEPTH(DEPTH), .PHYS_BITS(PB), .NUM_PHYS_REGS(NPR), .PAYLOAD_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (ifc.slave)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.flush       = 1'b0;
    ifc.enq_valid   = 1'b0;
    ifc.enq_uses_rs = 1'b0;
    ifc.enq_rs_phys = '0;
    ifc.enq_uses_rt = 1'b0;
    ifc.enq_rt_phys = '0;
    ifc.enq_rw_phys = '0;
    ifc.enq_payload = '0;
    ifc.wb_valid    = 1'b0;
    ifc.wb_phys     = '0;
    ifc.iss_ready   = 1'b0;
  endtask

  task automatic enq(input logic urs, input logic [PB-1:0] rs, input logic urt,
                     input logic [PB-1:0] rt, input logic [PB-1:0] rw, input logic [PW-1:0] pl);
    ifc.enq_valid   = 1'b1;
    ifc.enq_uses_rs = urs;
    ifc.enq_rs_phys = rs;
    ifc.enq_uses_rt = urt;
    ifc.enq_rt_phys = rt;
    ifc.enq_rw_phys = rw;
    ifc.enq_payload = pl;
    tick();
    ifc.enq_valid = 1'b0;
  endtask

  task automatic issue_one();
    ifc.iss_ready = 1'b1;
    tick();
    ifc.iss_ready = 1'b0;
  endtask

  task automatic wakeup(input logic [PB-1:0] tag);
    ifc.wb_valid = 1'b1;
    ifc.wb_phys  = tag;
    tick();
    ifc.wb_valid = 1'b0;
  endtask

  task automatic do_flush();
    ifc.flush = 1'b1;
    tick();
    ifc.flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    ifc.busy_bits = '0;
    repeat (2) tick();
    // Reset state
    check("rst_count", ifc.count, 0);
    check("rst_iss_valid", ifc.iss_valid, 0);
    check("rst_enq_ready", ifc.enq_ready, 0);
    check("rst_iss_not_x", $isunknown({ifc.iss_payload, ifc.iss_rw_phys}), 0);
    rst = 1'b0;
    #1;
    check("post_rst_enq_ready", ifc.enq_ready, 1);

    // Fill all 16 slots with ready instructions while execute stalls
    for (int i = 0; i < DEPTH; i++)
      enq(1'b1, PB'(i), 1'b1, PB'(i + 16), PB'(i + 32), 96'hA000 + PW'(i));
    check("full_count", ifc.count, 16);
    check("full_enq_ready", ifc.enq_ready, 0);
    check("full_iss_valid", ifc.iss_valid, 1);
    check("full_iss_rs", ifc.iss_rs_phys, 0);
    check("full_iss_rt", ifc.iss_rt_phys, 16);
    check("full_iss_rw", ifc.iss_rw_phys, 32);
    check("full_iss_payload", ifc.iss_payload, 96'hA000);
    enq(1'b1, 6'd63, 1'b1, 6'd63, 6'd63, '1);
    check("enq17_ignored_count", ifc.count, 16);
    check("enq17_ignored_head", ifc.iss_rw_phys, 32);
    do_flush();
    check("flush_full_count", ifc.count, 0);

    // Full queue where only slot 3 is ready; everything else waits on busy tags
    ifc.busy_bits = '1;
    for (int i = 0; i < DEPTH; i++)
      enq(i != 3, PB'(10 + i), 1'b0, '0, PB'(40 + i), 96'hB00 + PW'(i));
    check("slot3_iss_valid", ifc.iss_valid, 1);
    check("slot3_iss_rw", ifc.iss_rw_phys, 43);
    check("slot3_payload", ifc.iss_payload, 96'hB03);
    issue_one();
    check("slot3_count", ifc.count, 15);
    check("slot3_enq_ready", ifc.enq_ready, 1);
    check("slot3_none_ready", ifc.iss_valid, 0);
    ifc.wb_valid = 1'b1;
    ifc.wb_phys  = 6'd18;
    #1;
    check("wake_same_cycle", ifc.iss_valid, 0);
    tick();
    ifc.wb_valid = 1'b0;
    check("wake_next_cycle", ifc.iss_valid, 1);
    check("wake_shifted_rw", ifc.iss_rw_phys, 48);
    // Simultaneous enqueue and issue: new entry goes behind the 14 survivors
    ifc.iss_ready = 1'b1;
    enq(1'b1, 6'd60, 1'b0, '0, 6'd60, 96'hC0);
    ifc.iss_ready = 1'b0;
    check("enq_iss_count", ifc.count, 15);
    check("enq_iss_valid", ifc.iss_valid, 0);
    wakeup(6'd60);
    check("young_ready_rw", ifc.iss_rw_phys, 60);
    wakeup(6'd25);
    check("older_wins_rw", ifc.iss_rw_phys, 55);
    issue_one();
    check("after_old_count", ifc.count, 14);
    check("young_now_rw", ifc.iss_rw_phys, 60);
    check("young_payload", ifc.iss_payload, 96'hC0);
    issue_one();
    check("drain_count", ifc.count, 13);
    check("drain_iss_valid", ifc.iss_valid, 0);
    do_flush();

    // A waits on busy tag 5, younger B is ready and must issue first
    ifc.busy_bits    = '0;
    ifc.busy_bits[5] = 1'b1;
    ifc.busy_bits[9] = 1'b1;
    ifc.busy_bits[11] = 1'b1;
    enq(1'b1, 6'd5, 1'b0, '0, 6'd20, 96'h1A);
    check("a_not_ready", ifc.iss_valid, 0);
    enq(1'b1, 6'd6, 1'b0, '0, 6'd21, 96'h1B);
    check("b_selected_rw", ifc.iss_rw_phys, 21);
    check("ab_count", ifc.count, 2);
    issue_one();
    check("b_issued_count", ifc.count, 1);
    check("a_still_waiting", ifc.iss_valid, 0);
    ifc.wb_valid = 1'b1;
    ifc.wb_phys  = 6'd5;
    #1;
    check("a_wake_cycle_n", ifc.iss_valid, 0);
    tick();
    ifc.wb_valid = 1'b0;
    check("a_wake_cycle_n1", ifc.iss_valid, 1);
    check("a_rw", ifc.iss_rw_phys, 20);
    issue_one();
    check("a_issued_count", ifc.count, 0);

    // Writeback of the same tag in the enqueue cycle counts as ready
    ifc.wb_valid = 1'b1;
    ifc.wb_phys  = 6'd9;
    enq(1'b1, 6'd9, 1'b0, '0, 6'd22, 96'h1C);
    ifc.wb_valid = 1'b0;
    check("c_bypass_valid", ifc.iss_valid, 1);
    check("c_bypass_rw", ifc.iss_rw_phys, 22);
    issue_one();
    ifc.wb_valid = 1'b1;
    ifc.wb_phys  = 6'd11;
    enq(1'b0, '0, 1'b1, 6'd11, 6'd23, 96'h1D);
    ifc.wb_valid = 1'b0;
    check("d_rt_bypass_valid", ifc.iss_valid, 1);
    check("d_rt_bypass_rt", ifc.iss_rt_phys, 11);
    issue_one();
    check("cd_count", ifc.count, 0);

    // Flush beats enqueue, issue and wakeup in the same edge
    for (int i = 0; i < 7; i++)
      enq(1'b1, PB'(30 + i), 1'b0, '0, PB'(i), 96'hD0 + PW'(i));
    check("pre_flush_count", ifc.count, 7);
    ifc.flush        = 1'b1;
    ifc.wb_valid     = 1'b1;
    ifc.wb_phys      = 6'd30;
    ifc.iss_ready    = 1'b1;
    ifc.enq_valid    = 1'b1;
    ifc.enq_uses_rs  = 1'b0;
    ifc.enq_uses_rt  = 1'b0;
    ifc.enq_rw_phys  = 6'd40;
    #1;
    check("flush_enq_ready", ifc.enq_ready, 0);
    tick();
    idle();
    check("flush_count", ifc.count, 0);
    check("flush_iss_valid", ifc.iss_valid, 0);
    tick();
    check("flush_enq_absent", ifc.count, 0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 9; i++)
      enq(1'b1, PB'(30 + i), 1'b0, '0, PB'(1 + i), 96'hE0 + PW'(i));
    check("pre_rst_count", ifc.count, 9);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_iss_valid", ifc.iss_valid, 0);
    check("async_rst_enq_ready", ifc.enq_ready, 0);
    check("async_rst_count", ifc.count, 0);
    #2;
    rst = 1'b0;
    #1;
    check("rerst_enq_ready", ifc.enq_ready, 1);
    enq(1'b0, '0, 1'b0, '0, 6'd33, 96'hF00D);
    check("rerst_count", ifc.count, 1);
    check("rerst_slot0_rw", ifc.iss_rw_phys, 33);
    check("rerst_slot0_payload", ifc.iss_payload, 96'hF00D);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
